debounce_sync: RTL and testbench

- Front-end conditioning stage feeding the team's d_ff register stage.
- Takes a raw asynchronous, bouncy level (switch or off-chip strobe) and synchronises it into the clk domain.
- Debounces it with a consecutive-sample counter.
- Presents a clean level on q/qbar plus single-cycle rise/fall pulses, so the downstream flop's d input only ever sees stable, synchronous transitions.

---
 rtl/debounce_sync.sv | 129 ++++++++++++
 tb/tb_debounce_sync.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Synchroniser plus consecutive-sample debouncer producing a clean level and rise/fall pulses.
// Define DEBOUNCE_EVCNT_EN to add the ev_cnt rising-edge event counter output.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       q,
    output logic       qbar,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef DEBOUNCE_EVCNT_EN
    ,
    output logic [7:0] ev_cnt
`endif
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   qbar_q, qbar_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        qbar_d  = qbar_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s != q_q) begin
                    // A single required sample commits immediately, no qualification window.
                    if (DEBOUNCE_CYCLES == 1) begin
                        q_d    = s;
                        qbar_d = ~s;
                        rise_d = s;
                        fall_d = ~s;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = PENDING;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            PENDING: begin
                if (s == q_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = s;
                    qbar_d  = ~s;
                    rise_d  = s;
                    fall_d  = ~s;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
        busy_d = (state_d == PENDING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            qbar_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_EVCNT_EN
    logic [7:0] ev_q, ev_d;

    // Counts alongside the rise pulse so ev_cnt and rise change on the same edge.
    always_comb ev_d = ev_q + {7'd0, rise_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ev_q <= '0;
        else     ev_q <= ev_d;
    end

    assign ev_cnt = ev_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: default instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst, din, din1;
    logic q, qbar, rise, fall, busy;
    logic q1, qbar1, rise1, fall1, busy1;
`ifdef DEBOUNCE_EVCNT_EN
    logic [7:0] ev, ev1;
    logic [7:0] ev_m, ev_d;
`endif

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(10), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .q(q), .qbar(qbar),
        .rise(rise), .fall(fall), .busy(busy)
`ifdef DEBOUNCE_EVCNT_EN
        , .ev_cnt(ev)
`endif
    );

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .q(q1), .qbar(qbar1),
        .rise(rise1), .fall(fall1), .busy(busy1)
`ifdef DEBOUNCE_EVCNT_EN
        , .ev_cnt(ev1)
`endif
    );

    typedef struct {
        string       tag;
        logic [12:0] m;
        logic [12:0] d;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic        m_q, d_q;

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (ev,busy,rise,fall,qbar,q)", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] obs_m();
`ifdef DEBOUNCE_EVCNT_EN
        return {ev, busy, rise, fall, qbar, q};
`else
        return {8'd0, busy, rise, fall, qbar, q};
`endif
    endfunction

    function automatic logic [12:0] obs_d();
`ifdef DEBOUNCE_EVCNT_EN
        return {ev1, busy1, rise1, fall1, qbar1, q1};
`else
        return {8'd0, busy1, rise1, fall1, qbar1, q1};
`endif
    endfunction

    task automatic push(input string tag, input logic mq, input logic mr, input logic mf,
                        input logic mb, input logic dq, input logic dr, input logic df);
        exp_t e;
        logic [7:0] em, ed;
`ifdef DEBOUNCE_EVCNT_EN
        if (mr) ev_m++;
        if (dr) ev_d++;
        em = ev_m;
        ed = ev_d;
`else
        em = 8'd0;
        ed = 8'd0;
`endif
        e.tag = tag;
        e.m   = {em, mb, mr, mf, ~mq, mq};
        e.d   = {ed, 1'b0, dr, df, ~dq, dq};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 13'd1, 13'd0);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, "/m"}, obs_m(), e.m);
            check_eq({e.tag, "/d1"}, obs_d(), e.d);
        end
    endtask

    // Every task is entered and left in the low clock phase.
    task automatic step(input string tag, input logic mq, input logic mr, input logic mf,
                        input logic mb, input logic dq, input logic dr, input logic df);
        push(tag, mq, mr, mf, mb, dq, dr, df);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
    endtask

    task automatic reset_now(input string tag);
        rst = 1'b1;
        #1;
        m_q = 1'b0;
        d_q = 1'b0;
`ifdef DEBOUNCE_EVCNT_EN
        ev_m = 8'd0;
        ev_d = 8'd0;
`endif
        push(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_check();
    endtask

    task automatic idle(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            step(tag, m_q, 1'b0, 1'b0, 1'b0, d_q, 1'b0, 1'b0);
    endtask

    task automatic trans_main(input string tag, input logic lvl, input int unsigned n);
        logic qq;
        for (int unsigned k = 1; k <= n; k++) begin
            din = lvl;
            qq  = (k >= 12) ? lvl : ~lvl;
            step(tag, qq, lvl && k == 12, !lvl && k == 12, k >= 3 && k <= 11, d_q, 1'b0, 1'b0);
        end
        if (n >= 12) m_q = lvl;
    endtask

    task automatic d1_toggle(input string tag, input int unsigned n);
        logic lvl, qq;
        for (int unsigned t = 0; t < n; t++) begin
            lvl = ~d_q;
            for (int unsigned k = 1; k <= 4; k++) begin
                din1 = lvl;
                qq   = (k >= 3) ? lvl : ~lvl;
                step(tag, m_q, 1'b0, 1'b0, 1'b0, qq, lvl && k == 3, !lvl && k == 3);
            end
            d_q = lvl;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        din  = 1'b0;
        din1 = 1'b0;
        m_q  = 1'b0;
        d_q  = 1'b0;
`ifdef DEBOUNCE_EVCNT_EN
        ev_m = 8'd0;
        ev_d = 8'd0;
`endif
        @(negedge clk);
        reset_now("reset");

        // din already high when reset releases: qualifies as a normal rise
        din = 1'b1;
        rst = 1'b0;
        trans_main("rel_rise", 1'b1, 14);
        idle("hold_hi", 3);

        reset_now("rst_async_q1");
        idle("rst_hold", 2);
        din = 1'b0;
        rst = 1'b0;
        idle("post_rst", 3);

        trans_main("rise", 1'b1, 14);
        idle("idle_hi", 2);
        trans_main("fall", 1'b0, 14);
        idle("idle_lo", 2);

        for (int unsigned k = 1; k <= 21; k++) begin
            din = (k <= 5 || k >= 8);
            step("bounce", k >= 19, k == 19, 1'b0,
                 (k >= 3 && k <= 7) || (k >= 10 && k <= 18), d_q, 1'b0, 1'b0);
        end
        m_q = 1'b1;
        idle("idle_b", 2);
        trans_main("fall2", 1'b0, 14);
        idle("idle_lo2", 2);

        // abandon a qualification with the counter at 5
        trans_main("pend", 1'b1, 7);
        reset_now("rst_pend");
        idle("rst_pend_hold", 2);
        rst = 1'b0;
        trans_main("rel_rise2", 1'b1, 14);
        idle("idle_hi2", 2);

        d1_toggle("d1", 6);
        idle("idle_d1", 2);

`ifdef DEBOUNCE_EVCNT_EN
        din = 1'b0;
        reset_now("rst_ev");
        rst = 1'b0;
        idle("idle_ev", 2);
        d1_toggle("ev_wrap", 514);
        check_eq("ev_final", {5'd0, ev1}, 13'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
